posit_encode: RTL and testbench
===============================

# posit_encode

Packs one denormalized posit per transfer into a standard POSIT_WIDTH posit word. Inputs are sign, scale, MSB-aligned fraction with the hidden bit removed, NaR and zero flags. Rounding is round-to-nearest-even with posit saturation. The block is the consumer end of the arithmetic stream: it sits directly after `posit_mult`-style operators and uses the same rts/rtr/sow/eow streaming handshake, a one-entry input latch and a 3-stage pipeline.

## Interface
Parameters:
- POSIT_WIDTH, 32, posit word width N (≥ 8)
- POSIT_ES, 2, exponent field width
- IN_FORMAT, AMULT, posit_defines format selecting input fraction/scale widths (FW = get_fraction_width(POSIT_WIDTH,POSIT_ES,IN_FORMAT), SW = get_scale_width(...))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rtr_o  out  1  ready to receive (registered)
- rts_i  in  1  upstream valid
- sow_i, eow_i  in  1 each  start/end of window markers
- fraction_i  in  FW  MSB-aligned fraction, hidden bit removed
- scale_i  in  SW signed  scale = k·2^ES + e
- sign_i, NaR_i, zero_i  in  1 each  flags
- rtr_i  in  1  downstream ready
- rts_o  out  1  output valid
- sow_o, eow_o  out  1 each  markers aligned with posit_o
- posit_o  out  POSIT_WIDTH  encoded posit

## Operation
- Handshake:
  - process_en = rtr_i | ~rts_o.
  - receive_en = rts_i & rtr_o.
  - rtr_o is registered and equals process_en of the previous cycle.
- Skid latch:
  - Captures all inputs plus sow/eow when receive_en & ~process_en.
  - Releases when process_en is high.
  - The stage-1 input mux selects the latched copy while the latch is full.
- Stage enable: each stage loads when process_en & (previous valid | receive_en | latched). It clears its valid bit when process_en is high and nothing arrives. When process_en is low, all stages hold.
- Stage 1, decompose:
  - Clamp scale to [−(N−2)·2^ES, (N−2)·2^ES].
  - Record an over-range flag when the input was clamped on the positive side and an under-range flag on the negative side.
  - k = scale >>> ES (arithmetic), e = scale[ES−1:0].
  - Regime run length r = k+1 ones then a 0 when k ≥ 0; −k zeros then a 1 when k < 0.
- Stage 2, assemble:
  - Build regime|e|fraction as an (N−1+2)-bit field left-aligned into N−1 magnitude bits, plus guard bit G.
  - Sticky S = OR of all remaining shifted-out bits.
  - Keep L = LSB of the truncated magnitude.
- Stage 3, round/saturate/sign:
  - Increment the magnitude when G & (L | S).
  - Over-range or magnitude all-ones → maxpos 0x7F..F.
  - Under-range or magnitude zero with nonzero input → minpos 0x0..01. The encoder never rounds to zero or NaR.
  - Negative sign → two's complement of {0, magnitude}.
- Specials:
  - NaR_i → 1 followed by N−1 zeros, and takes precedence over zero_i.
  - zero_i → all zeros, and the sign is ignored.
- sow/eow travel unchanged alongside their datum.

## Timing
- Reset: rtr_o=0, rts_o=0, posit_o=0, sow_o=0, eow_o=0; the latch and all stage valids are cleared.
- Reset mid-operation discards all in-flight data.
- rtr_o rises in the first clk edge after reset release.
- Latency: 3 cycles from an accepted input to rts_o when unstalled. Throughput is 1 per cycle.
- Backpressure:
  - While rts_o=1 and rtr_i=0, posit_o, sow_o and eow_o hold stable.
  - At most one extra beat is accepted, into the latch, after rtr_i falls.
  - No beat is lost or duplicated.
- Simultaneous latch fill and release in the same cycle cannot occur: the fill requires ~process_en.

## Structure
- posit_defines gains:
  - get_max_scale(N,ES) = (N−2)·2^ES
  - the NaR pattern constant
- Existing get_fraction_width/get_scale_width are reused.
- One natural sub-module, posit_round_sat: combinational stage-3 logic (RNE increment, saturation, two's-complement sign). It is instantiated once.
- The handshake/latch logic stays inline, matching the other streaming operators.

## Test plan
All cases use N=32, ES=2.
- Basic encodings, no backpressure:
  - scale 0, fraction 0, sign 0 → 0x40000000 after 3 cycles
  - scale 1 → 0x48000000
  - sign 1, scale 0 → 0xC0000000
- Rounding at scale 0:
  - fraction with only the guard bit (bit below the 27th fraction bit) set → 0x40000000 (tie to even)
  - same plus any lower bit set → 0x40000001
  - fraction with 27 ones plus the guard bit → 0x48000000 (carry into exponent)
- Saturation:
  - scale 120 → 0x7FFFFFFF
  - scale 300 → 0x7FFFFFFF
  - scale −120 → 0x00000001
  - scale −300 → 0x00000001
  - sign 1 with scale 300 → 0x80000001
- Specials:
  - NaR_i=1 and zero_i=1 → 0x80000000
  - zero_i=1, sign 1 → 0x00000000
- Stream: 64 random beats with sow on beat 0 and eow on beat 63, rts_i and rtr_i randomly toggled → output sequence equals the reference-model sequence in order, with markers aligned, no loss or duplicates, and posit_o stable whenever rts_o & ~rtr_i.
- Reset: assert rst_n low with 3 beats in flight → next cycle all outputs 0. After release, the first output is the first beat sent post-reset.

Source files
------------

// File: rtl/posit_encode_pkg.sv
// Shared posit helpers: input format selector, field-width functions and the NaR pattern.
// The encoder, its rounding sub-block and sibling streaming operators all import this package.
package posit_encode_pkg;

  typedef enum logic [1:0] {
    POSIT,
    AADD,
    AMULT
  } posit_format_e;

  // Posits are at most 64 bits wide here; narrower words take the top N bits.
  localparam logic [63:0] NAR_PATTERN = 64'h8000_0000_0000_0000;

  function automatic int get_max_scale(input int n, input int es);
    return (n - 2) << es;
  endfunction

  function automatic int get_fraction_width(input int n, input int es, input posit_format_e fmt);
    int base;
    base = n - 3 - es;
    case (fmt)
      AADD:    return base + 3;
      AMULT:   return 2 * base + 1;
      default: return base;
    endcase
  endfunction

  function automatic int get_scale_width(input int n, input int es, input posit_format_e fmt);
    int extra;
    case (fmt)
      AADD:    extra = 2;
      AMULT:   extra = 3;
      default: extra = 1;
    endcase
    return $clog2(get_max_scale(n, es)) + extra;
  endfunction

endpackage

// File: rtl/posit_round_sat.sv
// Final encoder stage: round-to-nearest-even on the magnitude, saturate to maxpos/minpos,
// apply the sign, and substitute the NaR and zero patterns.
module posit_round_sat
  import posit_encode_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-2:0] mag_i,
  input  logic         guard_i,
  input  logic         sticky_i,
  input  logic         ovf_i,
  input  logic         unf_i,
  input  logic         sign_i,
  input  logic         nar_i,
  input  logic         zero_i,
  output logic [N-1:0] posit_o
);

  localparam logic [N-1:0] NAR    = NAR_PATTERN[63 -: N];
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N-1){1'b0}}, 1'b1};

  logic         round_up;
  logic [N-1:0] rounded;
  logic [N-1:0] mag_sat;

  always_comb begin
    round_up = guard_i & (mag_i[0] | sticky_i);
    rounded  = {1'b0, mag_i} + {{(N-1){1'b0}}, round_up};
    // An all-ones magnitude is already maxpos, so rounding must not wrap it.
    if (ovf_i | (&mag_i)) begin
      mag_sat = MAXPOS;
    end else if (unf_i | ~(|rounded)) begin
      mag_sat = MINPOS;
    end else begin
      mag_sat = rounded;
    end
    if (nar_i) begin
      posit_o = NAR;
    end else if (zero_i) begin
      posit_o = '0;
    end else if (sign_i) begin
      posit_o = -mag_sat;
    end else begin
      posit_o = mag_sat;
    end
  end

endmodule

// File: rtl/posit_encode.sv
// Streaming posit encoder: one-entry skid latch feeding a 3-stage pipeline
// (decompose scale, assemble regime/exponent/fraction, round/saturate/sign).
module posit_encode
  import posit_encode_pkg::*;
#(
  parameter int            POSIT_WIDTH = 32,
  parameter int            POSIT_ES    = 2,
  parameter posit_format_e IN_FORMAT   = AMULT,
  localparam int           FW          = get_fraction_width(POSIT_WIDTH, POSIT_ES, IN_FORMAT),
  localparam int           SW          = get_scale_width(POSIT_WIDTH, POSIT_ES, IN_FORMAT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   rtr_o,
  input  logic                   rts_i,
  input  logic                   sow_i,
  input  logic                   eow_i,
  input  logic [FW-1:0]          fraction_i,
  input  logic [SW-1:0]          scale_i,
  input  logic                   sign_i,
  input  logic                   NaR_i,
  input  logic                   zero_i,
  input  logic                   rtr_i,
  output logic                   rts_o,
  output logic                   sow_o,
  output logic                   eow_o,
  output logic [POSIT_WIDTH-1:0] posit_o
);

  localparam int N  = POSIT_WIDTH;
  localparam int ES = POSIT_ES;
  localparam int AW = $clog2(N);
  localparam int WW = 2 + ES + FW + N;
  localparam logic signed [SW-1:0] MAX_S = SW'(get_max_scale(N, ES));
  localparam logic signed [SW-1:0] MIN_S = -MAX_S;

  typedef struct packed {
    logic          sign;
    logic          nar;
    logic          zero;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
    logic          sow;
    logic          eow;
  } beat_t;

  typedef struct packed {
    logic          valid;
    logic          sign;
    logic          nar;
    logic          zero;
    logic          ovf;
    logic          unf;
    logic          kneg;
    logic [AW-1:0] amt;
    logic [ES-1:0] exp;
    logic [FW-1:0] frac;
    logic          sow;
    logic          eow;
  } s1_t;

  typedef struct packed {
    logic         valid;
    logic         sign;
    logic         nar;
    logic         zero;
    logic         ovf;
    logic         unf;
    logic [N-2:0] mag;
    logic         guard;
    logic         sticky;
    logic         sow;
    logic         eow;
  } s2_t;

  typedef struct packed {
    logic         valid;
    logic [N-1:0] posit;
    logic         sow;
    logic         eow;
  } s3_t;

  logic                 process_en, receive_en;
  logic                 rtr_q, rtr_d;
  logic                 lat_full_q, lat_full_d;
  beat_t                lat_q, lat_d, in_beat, cur;
  s1_t                  s1_q, s1_d;
  s2_t                  s2_q, s2_d;
  s3_t                  s3_q, s3_d;
  logic signed [SW-1:0] scale_in, scale_clamp, k;
  logic                 over, under;
  logic [WW-1:0]        field, shifted;
  logic [N-1:0]         round_posit;

  always_comb begin
    in_beat = '{sign: sign_i, nar: NaR_i, zero: zero_i, scale: scale_i,
                frac: fraction_i, sow: sow_i, eow: eow_i};
    process_en = rtr_i | ~s3_q.valid;
    receive_en = rts_i & rtr_q;
    rtr_d      = process_en;
    lat_full_d = lat_full_q;
    lat_d      = lat_q;
    if (process_en) begin
      lat_full_d = 1'b0;
    end else if (receive_en) begin
      lat_full_d = 1'b1;
      lat_d      = in_beat;
    end
    cur = lat_full_q ? lat_q : in_beat;
  end

  // Stage 1: clamp scale into the representable range and split it into regime run and exponent.
  always_comb begin
    scale_in    = cur.scale;
    over        = scale_in > MAX_S;
    under       = scale_in < MIN_S;
    scale_clamp = over ? MAX_S : (under ? MIN_S : scale_in);
    k           = scale_clamp >>> ES;
    s1_d        = s1_q;
    if (process_en) begin
      s1_d.valid = receive_en | lat_full_q;
      s1_d.sign  = cur.sign;
      s1_d.nar   = cur.nar;
      s1_d.zero  = cur.zero;
      s1_d.ovf   = over;
      s1_d.unf   = under;
      s1_d.kneg  = k[SW-1];
      s1_d.amt   = AW'(k[SW-1] ? ~k : k);
      s1_d.exp   = scale_clamp[ES-1:0];
      s1_d.frac  = cur.frac;
      s1_d.sow   = cur.sow;
      s1_d.eow   = cur.eow;
    end
  end

  // Stage 2: a "10" seed sign-extended right by k gives k+1 ones then 0; a "01" seed
  // shifted by -k-1 gives -k zeros then 1. Everything below the magnitude feeds G and S.
  always_comb begin
    field   = {(s1_q.kneg ? 2'b01 : 2'b10), s1_q.exp, s1_q.frac, {N{1'b0}}};
    shifted = $signed(field) >>> s1_q.amt;
    s2_d    = s2_q;
    if (process_en) begin
      s2_d.valid  = s1_q.valid;
      s2_d.sign   = s1_q.sign;
      s2_d.nar    = s1_q.nar;
      s2_d.zero   = s1_q.zero;
      s2_d.ovf    = s1_q.ovf;
      s2_d.unf    = s1_q.unf;
      s2_d.mag    = shifted[WW-1 -: N-1];
      s2_d.guard  = shifted[WW-N];
      s2_d.sticky = |shifted[WW-N-1:0];
      s2_d.sow    = s1_q.sow;
      s2_d.eow    = s1_q.eow;
    end
  end

  posit_round_sat #(
    .N(N)
  ) u_round_sat (
    .mag_i   (s2_q.mag),
    .guard_i (s2_q.guard),
    .sticky_i(s2_q.sticky),
    .ovf_i   (s2_q.ovf),
    .unf_i   (s2_q.unf),
    .sign_i  (s2_q.sign),
    .nar_i   (s2_q.nar),
    .zero_i  (s2_q.zero),
    .posit_o (round_posit)
  );

  always_comb begin
    s3_d = s3_q;
    if (process_en) begin
      s3_d.valid = s2_q.valid;
      s3_d.posit = round_posit;
      s3_d.sow   = s2_q.sow;
      s3_d.eow   = s2_q.eow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_q      <= 1'b0;
      lat_full_q <= 1'b0;
      lat_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
    end else begin
      rtr_q      <= rtr_d;
      lat_full_q <= lat_full_d;
      lat_q      <= lat_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
    end
  end

  assign rtr_o   = rtr_q;
  assign rts_o   = s3_q.valid;
  assign posit_o = s3_q.posit;
  assign sow_o   = s3_q.sow;
  assign eow_o   = s3_q.eow;

endmodule

// File: tb/tb_posit_encode.sv
// Directed and randomized-stream checks of posit_encode at N=32, ES=2 (AMULT input format:
// 55-bit fraction, 10-bit scale).
module tb_posit_encode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rtr_o, rts_i, sow_i, eow_i;
  logic [54:0] fraction_i;
  logic [9:0]  scale_i;
  logic        sign_i, NaR_i, zero_i, rtr_i;
  logic        rts_o, sow_o, eow_o;
  logic [31:0] posit_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] p;
    logic        sow;
    logic        eow;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  posit_encode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rtr_o     (rtr_o),
    .rts_i     (rts_i),
    .sow_i     (sow_i),
    .eow_i     (eow_i),
    .fraction_i(fraction_i),
    .scale_i   (scale_i),
    .sign_i    (sign_i),
    .NaR_i     (NaR_i),
    .zero_i    (zero_i),
    .rtr_i     (rtr_i),
    .rts_o     (rts_o),
    .sow_o     (sow_o),
    .eow_o     (eow_o),
    .posit_o   (posit_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input bit s, input int sc, input logic [54:0] fr,
                          input bit nar, input bit zr, input bit so, input bit eo);
    sign_i     = s;
    scale_i    = sc[9:0];
    fraction_i = fr;
    NaR_i      = nar;
    zero_i     = zr;
    sow_i      = so;
    eow_i      = eo;
  endtask

  // Bit-serial reference: lay out regime, exponent and fraction one bit at a time.
  function automatic logic [31:0] ref_enc(input bit s, input int sc_in, input logic [54:0] fr,
                                          input bit nar, input bit zr);
    logic [127:0] bits;
    logic [30:0]  mag;
    logic [31:0]  r, p;
    logic         g, st;
    bit           ovf, unf;
    int           sc, k, e, pos;
    if (nar) return 32'h8000_0000;
    if (zr) return 32'h0;
    sc  = sc_in;
    ovf = sc > 120;
    unf = sc < -120;
    if (ovf) sc = 120;
    if (unf) sc = -120;
    k    = sc >>> 2;
    e    = sc & 3;
    bits = '0;
    pos  = 127;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin bits[pos] = 1'b1; pos--; end
      bits[pos] = 1'b0; pos--;
    end else begin
      for (int i = 0; i < -k; i++) begin bits[pos] = 1'b0; pos--; end
      bits[pos] = 1'b1; pos--;
    end
    bits[pos] = e[1]; pos--;
    bits[pos] = e[0]; pos--;
    for (int i = 54; i >= 0; i--) begin bits[pos] = fr[i]; pos--; end
    mag = bits[127:97];
    g   = bits[96];
    st  = |bits[95:0];
    r   = {1'b0, mag};
    if (g && (mag[0] || st)) r = r + 32'd1;
    if (ovf || r >= 32'h7FFF_FFFF) p = 32'h7FFF_FFFF;
    else if (unf || r == 32'h0) p = 32'h1;
    else p = r;
    return s ? -p : p;
  endfunction

  // Sends one beat into an idle pipeline with rtr_i high and checks latency and result.
  task automatic encode_one(input string tag, input bit s, input int sc, input logic [54:0] fr,
                            input bit nar, input bit zr, input logic [31:0] exp);
    int lat;
    set_beat(s, sc, fr, nar, zr, 1'b0, 1'b0);
    rts_i = 1'b1;
    lat   = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) rts_i = 1'b0;
    end while (!rts_o && lat < 10);
    check({tag, "_latency"}, lat, 3);
    check(tag, posit_o, exp);
  endtask

  initial begin
    logic [54:0] fr_g, fr_gs, fr_carry;
    logic [63:0] rnd;
    logic [31:0] prev_posit;
    logic [1:0]  prev_marks;
    exp_t        ex;
    bit          hold_prev, need_new;
    int          sent, recv, sc;

    rst_n = 1'b0;
    rts_i = 1'b0;
    rtr_i = 1'b1;
    set_beat(1'b0, 0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_rtr_o", rtr_o, 0);
    check("reset_rts_o", rts_o, 0);
    check("reset_posit", posit_o, 0);
    check("reset_marks", {sow_o, eow_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rtr_after_reset", rtr_o, 1);

    fr_g     = 55'd1 << 27;
    fr_gs    = fr_g | 55'd1;
    fr_carry = ((55'd1 << 28) - 55'd1) << 27;
    encode_one("scale0",      1'b0, 0,    '0,       1'b0, 1'b0, 32'h4000_0000);
    encode_one("scale1",      1'b0, 1,    '0,       1'b0, 1'b0, 32'h4800_0000);
    encode_one("neg_scale0",  1'b1, 0,    '0,       1'b0, 1'b0, 32'hC000_0000);
    encode_one("scale_m1",    1'b0, -1,   '0,       1'b0, 1'b0, 32'h3800_0000);
    encode_one("scale4",      1'b0, 4,    '0,       1'b0, 1'b0, 32'h6000_0000);
    encode_one("rne_tie",     1'b0, 0,    fr_g,     1'b0, 1'b0, 32'h4000_0000);
    encode_one("rne_up",      1'b0, 0,    fr_gs,    1'b0, 1'b0, 32'h4000_0001);
    encode_one("rne_carry",   1'b0, 0,    fr_carry, 1'b0, 1'b0, 32'h4800_0000);
    encode_one("sat_120",     1'b0, 120,  '0,       1'b0, 1'b0, 32'h7FFF_FFFF);
    encode_one("sat_300",     1'b0, 300,  '0,       1'b0, 1'b0, 32'h7FFF_FFFF);
    encode_one("sat_m120",    1'b0, -120, '0,       1'b0, 1'b0, 32'h0000_0001);
    encode_one("sat_m300",    1'b0, -300, '0,       1'b0, 1'b0, 32'h0000_0001);
    encode_one("sat_neg300",  1'b1, 300,  '0,       1'b0, 1'b0, 32'h8000_0001);
    encode_one("nar_and_zero",1'b0, 5,    fr_gs,    1'b1, 1'b1, 32'h8000_0000);
    encode_one("zero_neg",    1'b1, 7,    fr_gs,    1'b0, 1'b1, 32'h0000_0000);

    // Reset with beats in flight, then confirm the first output is the first post-reset beat.
    set_beat(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    rts_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    rts_i = 1'b0;
    #1;
    check("midreset_rts_o", rts_o, 0);
    check("midreset_rtr_o", rtr_o, 0);
    check("midreset_posit", posit_o, 0);
    check("midreset_marks", {sow_o, eow_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    encode_one("post_reset", 1'b0, 1, '0, 1'b0, 1'b0, 32'h4800_0000);

    // Random stream with random valid/ready on both sides.
    sent      = 0;
    recv      = 0;
    hold_prev = 1'b0;
    need_new  = 1'b1;
    prev_posit = '0;
    prev_marks = '0;
    for (int cyc = 0; cyc < 3000 && recv < 64; cyc++) begin
      @(negedge clk);
      if (hold_prev) begin
        check("hold_rts", rts_o, 1);
        check("hold_posit", posit_o, prev_posit);
        check("hold_marks", {sow_o, eow_o}, prev_marks);
      end
      rtr_i = ($urandom_range(0, 3) != 0);
      if (rts_o && rtr_i) begin
        check("stream_extra_beat", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          ex = sb.pop_front();
          check($sformatf("stream_posit_%0d", recv), posit_o, ex.p);
          check($sformatf("stream_marks_%0d", recv), {sow_o, eow_o}, {ex.sow, ex.eow});
        end
        recv++;
      end
      hold_prev  = rts_o && !rtr_i;
      prev_posit = posit_o;
      prev_marks = {sow_o, eow_o};
      if (sent < 64) begin
        if (need_new) begin
          rnd = {$urandom, $urandom};
          sc  = int'($urandom_range(0, 600)) - 300;
          set_beat(1'($urandom_range(0, 1)), sc, rnd[54:0],
                   $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                   sent == 0, sent == 63);
          need_new = 1'b0;
        end
        rts_i = ($urandom_range(0, 3) != 0);
        if (rts_i && rtr_o) begin
          ex.p   = ref_enc(sign_i, sc, fraction_i, NaR_i, zero_i);
          ex.sow = sow_i;
          ex.eow = eow_i;
          sb.push_back(ex);
          sent++;
          need_new = 1'b1;
        end
      end else begin
        rts_i = 1'b0;
      end
    end
    check("stream_recv_count", recv, 64);
    check("stream_sent_count", sent, 64);
    check("stream_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
